// File: rtl/duty_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : duty_button_conditioner
// Description : Turns two raw push buttons into clean one-cycle
//               increase_duty / decrease_duty pulses for the PWM generator.
//               Each button has a 2-FF synchroniser, a debounce counter and
//               rising-edge detection. The two buttons exclude each other.
//               Optional hold-to-repeat behaviour is enabled by defining the
//               macro DUTY_BTN_AUTO_REPEAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module duty_button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 16,
    parameter int REPEAT_DELAY    = 20,
    parameter int REPEAT_PERIOD   = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_inc_raw,
    input  logic btn_dec_raw,
    output logic increase_duty,
    output logic decrease_duty,
    output logic inc_level,
    output logic dec_level
);

    // Channel 0 is "increase", channel 1 is "decrease".
    localparam int NUM_CH = 2;

    localparam longint          CNT_MAX  = (longint'(1) << CNT_W) - 1;
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    // The level flips on the edge where the counter would reach DEBOUNCE_CYCLES,
    // i.e. when it currently holds DEBOUNCE_CYCLES-1.
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Refuse to build a configuration whose counters cannot hold their limits.
    if (DEBOUNCE_CYCLES < 1 || longint'(DEBOUNCE_CYCLES) > CNT_MAX ||
        REPEAT_DELAY < 1    || longint'(REPEAT_DELAY) > CNT_MAX    ||
        REPEAT_PERIOD < 1   || longint'(REPEAT_PERIOD) > CNT_MAX) begin : g_param_check
        $error("duty_button_conditioner: counter width too small or limit below 1");
    end

    logic [NUM_CH-1:0] raw_w;      // raw button inputs, channel-indexed
    logic [NUM_CH-1:0] level_w;    // debounced stable levels
    logic [NUM_CH-1:0] level_prev_q;
    logic [NUM_CH-1:0] rise_w;     // stable level rose on the last edge
    logic [NUM_CH-1:0] press_w;    // rising edge that survives mutual exclusion
    logic [NUM_CH-1:0] pulse_d;
    logic [NUM_CH-1:0] pulse_q;

    assign raw_w = {btn_dec_raw, btn_inc_raw};

    // ------------------------------------------------------------------------
    // Per-button synchroniser and debounce
    // ------------------------------------------------------------------------
    for (genvar g = 0; g < NUM_CH; g++) begin : g_btn
        logic [1:0]       sync_q;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             level_q;
        logic             level_d;

        // Two-flop synchroniser for the asynchronous button input.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync_q <= 2'b00;
            end else begin
                sync_q <= {sync_q[0], raw_w[g]};
            end
        end

        // Count consecutive disagreeing samples; adopt the new level once enough accumulate.
        always_comb begin
            cnt_d   = '0;
            level_d = level_q;
            if (sync_q[1] != level_q) begin
                if (cnt_q >= DEB_LAST) begin
                    level_d = sync_q[1];
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
        end

        // Debounce counter and stable level registers.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q   <= '0;
                level_q <= 1'b0;
            end else begin
                cnt_q   <= cnt_d;
                level_q <= level_d;
            end
        end

        assign level_w[g] = level_q;
    end

    // ------------------------------------------------------------------------
    // Edge detection and mutual exclusion
    // ------------------------------------------------------------------------

    // Delayed copy of the stable levels for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_prev_q <= '0;
        end else begin
            level_prev_q <= level_w;
        end
    end

    assign rise_w = level_w & ~level_prev_q;

    // A rise is dropped while the other level is high. Simultaneous rises leave
    // both levels high together, so both are dropped by the same test.
    assign press_w[0] = rise_w[0] & ~level_w[1];
    assign press_w[1] = rise_w[1] & ~level_w[0];

`ifdef DUTY_BTN_AUTO_REPEAT_EN
    // ------------------------------------------------------------------------
    // Hold-to-repeat FSM, shared by both channels
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

    state_t            state_q;
    state_t            state_d;
    logic              ch_q;       // latched channel: 0 = increase, 1 = decrease
    logic              ch_d;
    logic [CNT_W-1:0]  rcnt_q;
    logic [CNT_W-1:0]  rcnt_d;
    logic [CNT_W-1:0]  rlimit_w;
    logic [NUM_CH-1:0] rep_w;

    // The first repeat waits the long delay, later ones the shorter period.
    assign rlimit_w = (state_q == ST_HOLD) ? DELAY_LAST : PERIOD_LAST;

    // Next-state logic: latch on a press, abort on release or a competing press.
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        rcnt_d  = rcnt_q;
        rep_w   = '0;
        case (state_q)
            ST_IDLE: begin
                if (|press_w) begin
                    state_d = ST_HOLD;
                    ch_d    = press_w[1];
                    rcnt_d  = '0;
                end
            end
            ST_HOLD, ST_REPEAT: begin
                if (!level_w[ch_q] || rise_w[~ch_q]) begin
                    state_d = ST_IDLE;
                    rcnt_d  = '0;
                end else if (rcnt_q >= rlimit_w) begin
                    rep_w[ch_q] = ~level_w[~ch_q];
                    state_d     = ST_REPEAT;
                    rcnt_d      = '0;
                end else begin
                    rcnt_d = rcnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                rcnt_d  = '0;
            end
        endcase
    end

    // Repeat FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ch_q    <= 1'b0;
            rcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            rcnt_q  <= rcnt_d;
        end
    end

    // A repeat never coincides with a press: presses on the latched channel are
    // impossible while it is held, and a press on the other one aborts the FSM.
    assign pulse_d = press_w | rep_w;
`else
    assign pulse_d = press_w;
`endif

    // Registered one-cycle output pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pulse_q <= '0;
        end else begin
            pulse_q <= pulse_d;
        end
    end

    assign increase_duty = pulse_q[0];
    assign decrease_duty = pulse_q[1];
    assign inc_level     = level_w[0];
    assign dec_level     = level_w[1];

endmodule
`default_nettype wire

// File: tb/tb_duty_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_duty_button_conditioner
// Description : Scoreboard bench for duty_button_conditioner. A behavioural
//               model predicts levels and pulses each cycle from the raw
//               sample history; a monitor compares every cycle. Directed
//               scenarios additionally check pulse timing lists.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_duty_button_conditioner;

    localparam int DEB    = 4;
    localparam int CW     = 16;
    localparam int RDELAY = 20;
    localparam int RPER   = 10;

    logic clk;
    logic rst_n;
    logic btn_inc_raw;
    logic btn_dec_raw;
    logic increase_duty;
    logic decrease_duty;
    logic inc_level;
    logic dec_level;

    duty_button_conditioner #(
        .DEBOUNCE_CYCLES (DEB),
        .CNT_W           (CW),
        .REPEAT_DELAY    (RDELAY),
        .REPEAT_PERIOD   (RPER)
    ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn_inc_raw   (btn_inc_raw),
        .btn_dec_raw   (btn_dec_raw),
        .increase_duty (increase_duty),
        .decrease_duty (decrease_duty),
        .inc_level     (inc_level),
        .dec_level     (dec_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected DUT state after one clock edge: {inc_level, dec_level, inc pulse, dec pulse}
    logic [3:0] exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;     // index of the next rising edge
    int inc_log[$];
    int dec_log[$];

    // ---------------- reference model ----------------
    bit       hist_inc[$];
    bit       hist_dec[$];
    logic [1:0] lvl;
    logic [1:0] lvl_prev;
    logic [1:0] m_rise;
    logic [1:0] m_press;
    logic [1:0] m_pulse;
    logic [1:0] m_new;
    bit       rep_active;
    bit       rep_ch;
    int       rep_next;

    // The synchroniser delays a raw sample by two edges; the level flips once
    // the DEB most recent synced samples all disagree with the current level.
    function automatic bit flips(input bit h[$], input bit cur);
        for (int k = 2; k <= DEB + 1; k++) begin
            if (h[h.size() - 1 - k] == cur) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_clear();
        hist_inc.delete();
        hist_dec.delete();
        for (int k = 0; k < DEB + 2; k++) begin
            hist_inc.push_back(1'b0);
            hist_dec.push_back(1'b0);
        end
        lvl        = 2'b00;
        lvl_prev   = 2'b00;
        rep_active = 1'b0;
        rep_ch     = 1'b0;
        rep_next   = 0;
    endtask

    initial model_clear();

    always @(posedge clk) begin
        int n;
        n = cyc;
        cyc = cyc + 1;
        if (!rst_n) begin
            model_clear();
            exp_q.push_back(4'b0000);
        end else begin
            hist_inc.push_back(btn_inc_raw);
            hist_dec.push_back(btn_dec_raw);
            while (hist_inc.size() > DEB + 3) void'(hist_inc.pop_front());
            while (hist_dec.size() > DEB + 3) void'(hist_dec.pop_front());

            m_rise     = lvl & ~lvl_prev;
            m_press[0] = m_rise[0] & ~lvl[1];
            m_press[1] = m_rise[1] & ~lvl[0];
            m_pulse    = m_press;
`ifdef DUTY_BTN_AUTO_REPEAT_EN
            if (rep_active) begin
                if (!lvl[rep_ch] || m_rise[!rep_ch]) begin
                    rep_active = 1'b0;
                end else if (n == rep_next) begin
                    m_pulse[rep_ch] = !lvl[!rep_ch];
                    rep_next = rep_next + RPER;
                end
            end else if (|m_press) begin
                rep_active = 1'b1;
                rep_ch     = m_press[1];
                rep_next   = n + RDELAY;
            end
`endif
            m_new[0] = lvl[0] ^ flips(hist_inc, lvl[0]);
            m_new[1] = lvl[1] ^ flips(hist_dec, lvl[1]);
            lvl_prev = lvl;
            lvl      = m_new;
            exp_q.push_back({m_new[0], m_new[1], m_pulse[0], m_pulse[1]});
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [3:0] e;
        logic [3:0] act;
        act = {inc_level, dec_level, increase_duty, decrease_duty};
        n_checks++;
        if (exp_q.size() == 0) begin
            $display("FAIL scoreboard_empty at edge %0d: got %b, no expectation", cyc - 1, act);
        end else begin
            e = exp_q.pop_front();
            if (!rst_n) e = 4'b0000;
            if (act !== e) begin
                $display("FAIL cycle_outputs edge %0d: got {inc_lvl,dec_lvl,inc,dec}=%b required %b",
                         cyc - 1, act, e);
            end else begin
                n_pass++;
            end
        end
        if (increase_duty === 1'b1) inc_log.push_back(cyc - 1);
        if (decrease_duty === 1'b1) dec_log.push_back(cyc - 1);
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic expect_log(input string name, input int got[$], input int want[$]);
        bit ok;
        ok = (got.size() == want.size());
        if (ok) begin
            for (int k = 0; k < got.size(); k++) if (got[k] != want[k]) ok = 1'b0;
        end
        n_checks++;
        if (ok) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d pulses (first at edge %0d) required %0d pulses (first at edge %0d)",
                     name, got.size(), (got.size() > 0) ? got[0] : -1,
                     want.size(), (want.size() > 0) ? want[0] : -1);
        end
    endtask

    task automatic clear_logs();
        inc_log.delete();
        dec_log.delete();
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        int t0;
        int t1;
        int want[$];
        int none[$];
        bit tgt_inc;
        bit tgt_dec;

        rst_n       = 1'b0;
        btn_inc_raw = 1'b0;
        btn_dec_raw = 1'b0;
        none.delete();
        step(3);
        rst_n = 1'b1;
        step(3);

        // Single press held for 10 cycles.
        clear_logs();
        t0 = cyc;
        btn_inc_raw = 1'b1;
        step(10);
        btn_inc_raw = 1'b0;
        step(16);
        want = {t0 + 6};
        expect_log("inc_press_timing", inc_log, want);
        expect_log("inc_press_no_dec", dec_log, none);

        // Bouncing decrease button, then a clean hold.
        clear_logs();
        btn_dec_raw = 1'b1; step(1);
        btn_dec_raw = 1'b0; step(1);
        btn_dec_raw = 1'b1; step(1);
        btn_dec_raw = 1'b0; step(1);
        t0 = cyc;
        btn_dec_raw = 1'b1;
        step(12);
        btn_dec_raw = 1'b0;
        step(16);
        want = {t0 + 6};
        expect_log("dec_bounce_then_hold", dec_log, want);
        expect_log("dec_bounce_no_inc", inc_log, none);

        // Increase held, decrease pressed on top of it.
        clear_logs();
        t0 = cyc;
        btn_inc_raw = 1'b1;
        step(12);
        btn_dec_raw = 1'b1;
        step(12);
        btn_inc_raw = 1'b0;
        btn_dec_raw = 1'b0;
        step(16);
        want = {t0 + 6};
        expect_log("excl_inc_first", inc_log, want);
        expect_log("excl_dec_ignored", dec_log, none);

        // Both pressed in the same cycle.
        clear_logs();
        btn_inc_raw = 1'b1;
        btn_dec_raw = 1'b1;
        step(30);
        btn_inc_raw = 1'b0;
        btn_dec_raw = 1'b0;
        step(16);
        expect_log("both_same_cycle_inc", inc_log, none);
        expect_log("both_same_cycle_dec", dec_log, none);

        // Reset while the increase button is held.
        clear_logs();
        t0 = cyc;
        btn_inc_raw = 1'b1;
        step(8);
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        t1 = cyc;
        step(10);
        btn_inc_raw = 1'b0;
        step(16);
        want = {t0 + 6, t1 + 6};
        expect_log("reset_midhold", inc_log, want);

        // Long hold: repeats only when auto-repeat is built in.
        clear_logs();
        t0 = cyc;
        btn_inc_raw = 1'b1;
        step(60);
        btn_inc_raw = 1'b0;
        step(20);
`ifdef DUTY_BTN_AUTO_REPEAT_EN
        want = {t0 + 6, t0 + 26, t0 + 36, t0 + 46, t0 + 56};
`else
        want = {t0 + 6};
`endif
        expect_log("long_hold", inc_log, want);
        expect_log("long_hold_no_dec", dec_log, none);

        // Randomised bouncing buttons with occasional resets.
        tgt_inc = 1'b0;
        tgt_dec = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 29) == 0) tgt_inc = ~tgt_inc;
            if ($urandom_range(0, 29) == 0) tgt_dec = ~tgt_dec;
            btn_inc_raw = tgt_inc ^ ($urandom_range(0, 7) == 0);
            btn_dec_raw = tgt_dec ^ ($urandom_range(0, 7) == 0);
            if (rst_n && $urandom_range(0, 499) == 0) rst_n = 1'b0;
            else if (!rst_n && $urandom_range(0, 1) == 1) rst_n = 1'b1;
            step(1);
        end
        rst_n       = 1'b1;
        btn_inc_raw = 1'b0;
        btn_dec_raw = 1'b0;
        step(20);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
